// File: rtl/obuf_requant_drain.sv
// Requantizes one packed 128-bit MAC result word into signed 8-bit lanes streamed one per cycle.
// Latency: first lane two cycles after the accept cycle (IDLE -> PREP -> DRAIN), then 1 lane/cycle.
// Backpressure: in_ready low while a word drains; output lane held stable until out_ready.
module obuf_requant_drain #(
  parameter int SHIFT_W  = 4,
  parameter int SATCNT_W = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [1:0]          mode,
  input  logic [SHIFT_W-1:0]  shift,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic [3:0]          out_lane,
  output logic                out_last,
  output logic                err,
  output logic [SATCNT_W-1:0] sat_count,
  input  logic                sat_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] MODE_2B  = 2'b00;
  localparam logic [1:0] MODE_4B  = 2'b01;
  localparam logic [1:0] MODE_ILL = 2'b11;

  state_e                state_q, state_d;
  logic [127:0]          word_q;
  logic [1:0]            mode_q;
  logic [SHIFT_W-1:0]    shift_q;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            out_data_q, out_data_d;
  logic [3:0]            out_lane_q, out_lane_d;
  logic                  out_last_q, out_last_d;
  logic                  lane_sat_q, lane_sat_d;
  logic                  err_q;
  logic [SATCNT_W-1:0]   sat_count_q;

  logic                  accept;
  logic                  out_hs;
  logic [3:0]            lane_sel;
  logic [6:0]            off12;
  logic [7:0]            f8;
  logic [11:0]           f12;
  logic [19:0]           f20;
  logic signed [20:0]    lane_val;
  logic                  lane_is_last;
  logic signed [20:0]    rnd;
  logic signed [20:0]    sum;
  logic signed [20:0]    shifted;
  logic [7:0]            rq_data;
  logic                  rq_sat;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_ready && in_valid;
  assign out_hs    = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
  assign sat_count = sat_count_q;

  // Lane to load next: lane 0 in PREP, otherwise the successor of the lane on the port.
  always_comb begin
    lane_sel = 4'd0;
    if (state_q == DRAIN) begin
      lane_sel = out_lane_q + 4'd1;
    end
  end

  // Unpack the selected lane from the captured word and sign-extend to 21 bits.
  always_comb begin
    off12        = 7'({lane_sel[1:0], 3'b000}) + 7'({lane_sel[1:0], 2'b00});
    f8           = word_q[{lane_sel, 3'b000} +: 8];
    f12          = word_q[off12 +: 12];
    f20          = word_q[19:0];
    lane_val     = {f20[19], f20};
    lane_is_last = 1'b1;
    case (mode_q)
      MODE_2B: begin
        lane_val     = {{13{f8[7]}}, f8};
        lane_is_last = (lane_sel == 4'd15);
      end
      MODE_4B: begin
        lane_val     = {{9{f12[11]}}, f12};
        lane_is_last = (lane_sel == 4'd3);
      end
      default: begin
        lane_val     = {f20[19], f20};
        lane_is_last = 1'b1;
      end
    endcase
  end

  // Round half-up, arithmetic shift, clamp to signed 8 bits; 21 bits cannot overflow here.
  always_comb begin
    rnd = '0;
    if (shift_q != '0) begin
      rnd = 21'(1) << (shift_q - SHIFT_W'(1));
    end
    sum     = lane_val + rnd;
    shifted = sum >>> shift_q;
    rq_data = shifted[7:0];
    rq_sat  = 1'b0;
    if (shifted > 21'sd127) begin
      rq_data = 8'h7F;
      rq_sat  = 1'b1;
    end else if (shifted < -21'sd128) begin
      rq_data = 8'h80;
      rq_sat  = 1'b1;
    end
  end

  // Next-state and output-register logic for the drain FSM.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    out_last_d  = out_last_q;
    lane_sat_d  = lane_sat_q;
    case (state_q)
      IDLE: begin
        if (accept && (mode != MODE_ILL)) begin
          state_d = PREP;
        end
      end
      PREP: begin
        state_d     = DRAIN;
        out_valid_d = 1'b1;
        out_data_d  = rq_data;
        out_lane_d  = lane_sel;
        out_last_d  = lane_is_last;
        lane_sat_d  = rq_sat;
      end
      DRAIN: begin
        if (out_hs) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end else begin
            out_data_d = rq_data;
            out_lane_d = lane_sel;
            out_last_d = lane_is_last;
            lane_sat_d = rq_sat;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and output lane registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
      lane_sat_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      out_last_q  <= out_last_d;
      lane_sat_q  <= lane_sat_d;
    end
  end

  // Capture word, mode and shift on accept so later input changes cannot disturb the drain.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      word_q  <= '0;
      mode_q  <= '0;
      shift_q <= '0;
    end else if (accept) begin
      word_q  <= in_data;
      mode_q  <= mode;
      shift_q <= shift;
    end
  end

  // One-cycle error pulse for an accepted word with the reserved mode encoding.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && (mode == MODE_ILL);
    end
  end

  // Saturation statistic: clear wins, otherwise count saturated lanes as they leave, sticky at max.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sat_count_q <= '0;
    end else if (sat_clr) begin
      sat_count_q <= '0;
    end else if (out_hs && lane_sat_q && (sat_count_q != '1)) begin
      sat_count_q <= sat_count_q + SATCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_obuf_requant_drain.sv
// Randomized bench for obuf_requant_drain with a lane-list reference model and scoreboard.
// Inputs driven 1ns after the rising edge; outputs sampled on the falling edge.
// Summary line reports comparisons made and mismatches found.
module tb_obuf_requant_drain;

  localparam int SW      = 4;
  localparam int CW      = 5;
  localparam int SAT_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           nrst;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [1:0]     mode;
  logic [SW-1:0]  shift;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     out_data;
  logic [3:0]     out_lane;
  logic           out_last;
  logic           err;
  logic [CW-1:0]  sat_count;
  logic           sat_clr;

  always #5 clk = ~clk;

  obuf_requant_drain #(.SHIFT_W(SW), .SATCNT_W(CW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .err       (err),
    .sat_count (sat_count),
    .sat_clr   (sat_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] dat;
    logic [3:0] lane;
    logic       last;
    logic       sat;
  } exp_t;

  exp_t       exp_q[$];
  int         sat_model  = 0;
  int         hs_cnt     = 0;
  int         ready_mode = 0;
  bit         stall      = 0;
  bit         idle_chk   = 0;
  logic [7:0] held_dat;
  logic [3:0] held_lane;
  logic       held_last;

  // Reference: split the word into lanes by mode, then requantize with integer floor division.
  function automatic void model_word(input logic [127:0] d, input logic [1:0] m, input int s);
    int n;
    int w;
    n = (m == 2'b00) ? 16 : (m == 2'b01) ? 4 : 1;
    w = (m == 2'b00) ? 8 : (m == 2'b01) ? 12 : 20;
    for (int i = 0; i < n; i++) begin
      int   v;
      int   r;
      int   q;
      int   p;
      exp_t e;
      v = 0;
      for (int b = 0; b < w; b++) if (d[w*i+b]) v += (1 << b);
      if (v >= (1 << (w - 1))) v -= (1 << w);
      p = 1 << s;
      r = v + ((s > 0) ? (1 << (s - 1)) : 0);
      q = r / p;
      if ((r % p) != 0 && r < 0) q = q - 1;
      e.sat = 1'b0;
      if (q > 127) begin q = 127; e.sat = 1'b1; end
      else if (q < -128) begin q = -128; e.sat = 1'b1; end
      e.dat  = q[7:0];
      e.lane = 4'(i);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Output-ready pattern: always, alternating, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: checks each lane handshake, hold-while-stalled, busy in_ready and the counter.
  always @(negedge clk) begin
    exp_t e;
    if (!nrst) begin
      stall    = 0;
      idle_chk = 0;
    end else begin
      chk("sat_count", 64'(sat_count), 64'(sat_model));
      if (idle_chk) begin
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        idle_chk = 0;
      end
      if (out_valid) begin
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        if (stall) begin
          chk("hold_data", 64'(out_data), 64'(held_dat));
          chk("hold_lane", 64'(out_lane), 64'(held_lane));
          chk("hold_last", 64'(out_last), 64'(held_last));
        end
        if (out_ready) begin
          stall = 0;
          hs_cnt++;
          chk("lane_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_data", 64'(out_data), 64'(e.dat));
            chk("out_lane", 64'(out_lane), 64'(e.lane));
            chk("out_last", 64'(out_last), 64'(e.last));
            if (e.sat && !sat_clr && sat_model < SAT_MAX) sat_model++;
            if (e.last) idle_chk = 1;
          end
        end else begin
          stall     = 1;
          held_dat  = out_data;
          held_lane = out_lane;
          held_last = out_last;
        end
      end
      if (sat_clr) sat_model = 0;
    end
  end

  task automatic send_word(input logic [127:0] d, input logic [1:0] m, input int s, input bit clr);
    bit ok;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    shift    = SW'(s);
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    if (m != 2'b11) model_word(d, m, s);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    mode     = 2'($urandom);
    shift    = SW'($urandom);
    if (m == 2'b11) begin
      @(negedge clk);
      chk("err_pulse", 64'(err), 64'd1);
      chk("err_in_ready", 64'(in_ready), 64'd1);
      chk("err_no_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("err_one_cycle", 64'(err), 64'd0);
      chk("err_no_valid2", 64'(out_valid), 64'd0);
    end else begin
      @(negedge clk);
      chk("lat_prep_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      sat_clr = clr;
      @(negedge clk);
      chk("lat_first_valid", 64'(out_valid), 64'd1);
      chk("lat_first_lane", 64'(out_lane), 64'd0);
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (in_ready && exp_q.size() == 0) begin ok = 1; break; end
    end
    chk("drain_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int           h0;
    int           r;
    logic [1:0]   m;
    bit           ok;

    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 2'b00;
    shift     = '0;
    sat_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_lane", 64'(out_lane), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // 8-bit mode: +400 and -400 with shift 2, then +400 unshifted saturates.
    send_word(128'h00190, 2'b10, 2, 1'b0);
    d = {$urandom, $urandom, $urandom, 12'($urandom), 20'hFFE70};
    send_word(d, 2'b10, 2, 1'b0);
    send_word(128'h00190, 2'b10, 0, 1'b0);
    wait_idle();
    chk("sat_after_8b", 64'(sat_count), 64'd1);

    // 4-bit mode: lanes 00A, FF6, 7FF, 800 with shift 1; two lanes saturate.
    d = {$urandom, $urandom, 16'($urandom), 12'h800, 12'h7FF, 12'hFF6, 12'h00A};
    send_word(d, 2'b01, 1, 1'b0);
    wait_idle();
    chk("sat_after_4b", 64'(sat_count), 64'd3);

    // 2-bit mode: lane i holds i, alternating out_ready.
    ready_mode = 1;
    for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
    h0 = hs_cnt;
    send_word(d, 2'b00, 0, 1'b0);
    wait_idle();
    chk("hs_count_2b", 64'(hs_cnt - h0), 64'd16);

    // Illegal mode then a normal (saturating) word.
    ready_mode = 0;
    send_word({$urandom, $urandom, $urandom, $urandom}, 2'b11, 3, 1'b0);
    send_word(128'h00190, 2'b10, 0, 1'b0);
    wait_idle();

    // Asynchronous reset while lane 5 of a 2-bit word is on the port.
    send_word({$urandom, $urandom, $urandom, $urandom}, 2'b00, 1, 1'b0);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid && out_lane == 4'd5) begin ok = 1; break; end
    end
    chk("reach_lane5", 64'(ok), 64'd1);
    #2;
    nrst = 1'b0;
    exp_q.delete();
    sat_model = 0;
    stall     = 0;
    idle_chk  = 0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_sat_count", 64'(sat_count), 64'd0);
    chk("arst_out_lane", 64'(out_lane), 64'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // Clear coinciding with a saturating handshake wins.
    send_word(128'h00190, 2'b10, 0, 1'b0);
    wait_idle();
    chk("sat_before_clr", 64'(sat_count), 64'd1);
    send_word(128'h00190, 2'b10, 0, 1'b1);
    wait_idle();
    chk("sat_clr_priority", 64'(sat_count), 64'd0);

    // Random traffic.
    for (int it = 0; it < 150; it++) begin
      ready_mode = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      m = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      send_word({$urandom, $urandom, $urandom, $urandom}, m, $urandom_range(0, 15),
                ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 7) == 0) wait_idle();
    end
    wait_idle();
    chk("final_sat_count", 64'(sat_count), 64'(sat_model));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
